// File: rtl/s2_conv_scheduler.sv
// s2_conv_scheduler -- stage-2 convolution sequencer.
//
// Once per frame, after start, sweeps N_DIR filters x N_POS output positions,
// driving dir/counter into the combinational tensor-processing path. Issues
// are tracked through a LAT-deep pipeline whose head is presented downstream
// with a valid/ready handshake. Backpressure freezes the issue counters, the
// FSM and the whole pipeline together.
//
// Ports:
//   clk, reset (async, active-low)
//   start        single-cycle frame start (ignored unless idle)
//   abort        synchronous flush, wins over start
//   dir/counter  registered filter select / output position
//   issue_valid  dir/counter hold a live issue
//   res_valid/res_ready/res_addr/res_index  result handshake and tag
//   busy, done   frame in progress / one-cycle completion pulse
//   stall_cycles per-frame backpressure cycle count
//
// Build option: define S2_SCHED_STATS_EN to build the stall counter;
// otherwise stall_cycles is tied to zero.
module s2_conv_scheduler #(
  parameter int unsigned N_DIR = 4,
  parameter int unsigned N_POS = 36,
  parameter int unsigned LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [1:0]  dir,
  output logic [5:0]  counter,
  output logic        issue_valid,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_addr,
  output logic [7:0]  res_index,
  output logic        busy,
  output logic        done,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [1:0] DIR_LAST = 2'(N_DIR - 1);
  localparam logic [5:0] POS_LAST = 6'(N_POS - 1);

  state_t     state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic [5:0] cnt_q, cnt_d;

  logic       pv_q [LAT];
  logic [1:0] pd_q [LAT];
  logic [5:0] pc_q [LAT];

  logic en;
  logic start_acc;
  logic flush;
  logic inflight;

  assign en        = !(res_valid && !res_ready);
  assign start_acc = (state_q == S_IDLE) && start && !abort;
  assign flush     = abort && ((state_q == S_RUN) || (state_q == S_DRAIN));

  // With en=1 the head result is either absent or accepted this cycle, so the
  // pipeline is empty after the edge once every stage behind the head is empty.
  always_comb begin
    inflight = 1'b0;
    for (int unsigned i = 0; i + 1 < LAT; i++) begin
      inflight = inflight | pv_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    issue_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_acc) state_d = S_RUN;
      end
      S_RUN: begin
        issue_valid = 1'b1;
        busy        = 1'b1;
        if (en) begin
          if (dir_q == DIR_LAST && cnt_q == POS_LAST) begin
            state_d = S_DRAIN;
            dir_d   = '0;
            cnt_d   = '0;
          end else if (cnt_q == POS_LAST) begin
            cnt_d = '0;
            dir_d = dir_q + 2'd1;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (en && !inflight) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      dir_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      dir_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        pv_q[i] <= 1'b0;
        pd_q[i] <= '0;
        pc_q[i] <= '0;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        pv_q[i] <= 1'b0;
      end
    end else if (en) begin
      pv_q[0] <= issue_valid;
      pd_q[0] <= dir_q;
      pc_q[0] <= cnt_q;
      for (int unsigned i = 1; i < LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pd_q[i] <= pd_q[i-1];
        pc_q[i] <= pc_q[i-1];
      end
    end
  end

  assign dir       = dir_q;
  assign counter   = cnt_q;
  assign res_valid = pv_q[LAT-1];
  assign res_addr  = {pd_q[LAT-1], pc_q[LAT-1]};
  assign res_index = 8'(pd_q[LAT-1]) * 8'd36 + 8'(pc_q[LAT-1]);

`ifdef S2_SCHED_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if (res_valid && !res_ready && stall_q != '1) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_s2_conv_scheduler.sv
// Self-checking bench for s2_conv_scheduler. Three instances (LAT=2, 4, 1)
// share all inputs. A frame-time model (count of enabled cycles since start)
// predicts every output per cycle; literal checks pin frame timing.
module tb_s2_conv_scheduler;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset, start, abort, res_ready;

  logic [1:0]  o_dir   [NI];
  logic [5:0]  o_cnt   [NI];
  logic        o_iv    [NI];
  logic        o_rv    [NI];
  logic [7:0]  o_addr  [NI];
  logic [7:0]  o_idx   [NI];
  logic        o_busy  [NI];
  logic        o_done  [NI];
  logic [15:0] o_stall [NI];

  always #5 clk = ~clk;

  s2_conv_scheduler #(.N_DIR(4), .N_POS(36), .LAT(2)) u0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .dir(o_dir[0]), .counter(o_cnt[0]), .issue_valid(o_iv[0]),
    .res_valid(o_rv[0]), .res_ready(res_ready), .res_addr(o_addr[0]),
    .res_index(o_idx[0]), .busy(o_busy[0]), .done(o_done[0]),
    .stall_cycles(o_stall[0]));

  s2_conv_scheduler #(.N_DIR(4), .N_POS(36), .LAT(4)) u1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .dir(o_dir[1]), .counter(o_cnt[1]), .issue_valid(o_iv[1]),
    .res_valid(o_rv[1]), .res_ready(res_ready), .res_addr(o_addr[1]),
    .res_index(o_idx[1]), .busy(o_busy[1]), .done(o_done[1]),
    .stall_cycles(o_stall[1]));

  s2_conv_scheduler #(.N_DIR(4), .N_POS(36), .LAT(1)) u2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .dir(o_dir[2]), .counter(o_cnt[2]), .issue_valid(o_iv[2]),
    .res_valid(o_rv[2]), .res_ready(res_ready), .res_addr(o_addr[2]),
    .res_index(o_idx[2]), .busy(o_busy[2]), .done(o_done[2]),
    .stall_cycles(o_stall[2]));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(int i);
    case (i)
      0:       return 2;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc - start_cyc);
    end
  endtask

  // Model: a frame is a count t of enabled cycles since start acceptance.
  // Issue k is at t=k+1, result r at t=r+1+LAT, done at t=145+LAT.
  bit m_act   [NI];
  int m_t     [NI];
  int m_stall [NI];

  function automatic bit m_issue(int i);
    return m_act[i] && m_t[i] >= 1 && m_t[i] <= 144;
  endfunction
  function automatic bit m_rv(int i);
    return m_act[i] && m_t[i] >= 1 + lat_of(i) && m_t[i] <= 144 + lat_of(i);
  endfunction
  function automatic bit m_busy(int i);
    return m_act[i] && m_t[i] <= 144 + lat_of(i);
  endfunction
  function automatic bit m_done(int i);
    return m_act[i] && m_t[i] == 145 + lat_of(i);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NI; i++) begin
        m_act[i]   <= 1'b0;
        m_t[i]     <= 0;
        m_stall[i] <= 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (!m_act[i]) begin
          if (start && !abort) begin
            m_act[i]   <= 1'b1;
            m_t[i]     <= 1;
            m_stall[i] <= 0;
          end
        end else begin
          if (m_rv(i) && !res_ready && m_stall[i] != 65535) m_stall[i] <= m_stall[i] + 1;
          if (m_done(i) || abort) m_act[i] <= 1'b0;
          else if (!(m_rv(i) && !res_ready)) m_t[i] <= m_t[i] + 1;
        end
      end
    end
  end

  // Per-frame observations, cleared at each start.
  int acc_cnt    [NI];
  int first_idx  [NI];
  int first_rv   [NI];
  int done_cnt   [NI];
  int done_rel   [NI];
  int busy_first [NI];
  int busy_last  [NI];

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        int k, r, rel, es;
        rel = cyc - start_cyc;
        chk($sformatf("u%0d.issue_valid", i), int'(o_iv[i]), int'(m_issue(i)));
        chk($sformatf("u%0d.busy", i), int'(o_busy[i]), int'(m_busy(i)));
        chk($sformatf("u%0d.done", i), int'(o_done[i]), int'(m_done(i)));
        chk($sformatf("u%0d.res_valid", i), int'(o_rv[i]), int'(m_rv(i)));
        if (m_issue(i)) begin
          k = m_t[i] - 1;
          chk($sformatf("u%0d.dir", i), int'(o_dir[i]), k / 36);
          chk($sformatf("u%0d.counter", i), int'(o_cnt[i]), k % 36);
        end
        if (!m_act[i]) begin
          chk($sformatf("u%0d.dir_idle", i), int'(o_dir[i]), 0);
          chk($sformatf("u%0d.counter_idle", i), int'(o_cnt[i]), 0);
        end
        if (m_rv(i)) begin
          r = m_t[i] - 1 - lat_of(i);
          chk($sformatf("u%0d.res_index", i), int'(o_idx[i]), r);
          chk($sformatf("u%0d.res_addr", i), int'(o_addr[i]), (r / 36) * 64 + (r % 36));
        end
`ifdef S2_SCHED_STATS_EN
        es = m_stall[i];
`else
        es = 0;
`endif
        chk($sformatf("u%0d.stall_cycles", i), int'(o_stall[i]), es);
        if (o_rv[i] && res_ready) begin
          if (acc_cnt[i] == 0) first_idx[i] = int'(o_idx[i]);
          chk($sformatf("u%0d.accept_order", i), int'(o_idx[i]), acc_cnt[i]);
          acc_cnt[i]++;
        end
        if (i == 0 && o_rv[i] && o_idx[i] == 8'd36)
          chk("u0.res_addr_at_36", int'(o_addr[i]), 8'h40);
        if (o_rv[i] && first_rv[i] < 0) first_rv[i] = rel;
        if (o_done[i]) begin
          done_cnt[i]++;
          done_rel[i] = rel;
        end
        if (o_busy[i]) begin
          if (busy_first[i] < 0) busy_first[i] = rel;
          busy_last[i] = rel;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    for (int i = 0; i < NI; i++) begin
      acc_cnt[i] = 0;   first_idx[i] = -1; first_rv[i] = -1;
      done_cnt[i] = 0;  done_rel[i] = -1;
      busy_first[i] = -1; busy_last[i] = -1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    start_cyc = cyc;
    clr_stats();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (!(done_cnt[0] > 0 && done_cnt[1] > 0 && done_cnt[2] > 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) chk("wait_done_timeout", n, -1);
    tick();
  endtask

  task automatic wait_rel(int target);
    int n = 0;
    while (cyc - start_cyc < target && n < 400) begin
      tick();
      n++;
    end
    chk("wait_rel", cyc - start_cyc, target);
  endtask

  task automatic chk_zero_outputs(string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s.u%0d.dir", tag, i), int'(o_dir[i]), 0);
      chk($sformatf("%s.u%0d.counter", tag, i), int'(o_cnt[i]), 0);
      chk($sformatf("%s.u%0d.issue_valid", tag, i), int'(o_iv[i]), 0);
      chk($sformatf("%s.u%0d.res_valid", tag, i), int'(o_rv[i]), 0);
      chk($sformatf("%s.u%0d.res_addr", tag, i), int'(o_addr[i]), 0);
      chk($sformatf("%s.u%0d.res_index", tag, i), int'(o_idx[i]), 0);
      chk($sformatf("%s.u%0d.busy", tag, i), int'(o_busy[i]), 0);
      chk($sformatf("%s.u%0d.done", tag, i), int'(o_done[i]), 0);
      chk($sformatf("%s.u%0d.stall", tag, i), int'(o_stall[i]), 0);
    end
  endtask

  // Literal frame timing for LAT = 2, 4, 1.
  task automatic chk_frame(string tag, int d0, int d1, int d2);
    int dexp [NI];
    dexp[0] = d0; dexp[1] = d1; dexp[2] = d2;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s.u%0d.done_cycle", tag, i), done_rel[i], dexp[i]);
      chk($sformatf("%s.u%0d.done_count", tag, i), done_cnt[i], 1);
      chk($sformatf("%s.u%0d.results", tag, i), acc_cnt[i], 144);
      chk($sformatf("%s.u%0d.first_index", tag, i), first_idx[i], 0);
    end
  endtask

  initial begin
    int n;
    int exp_stall;
    reset = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
    clr_stats();
    #2;
    chk_zero_outputs("reset");
    tick(); tick();
    reset = 1'b1;
    tick();

    // Frame A: clean run.
    do_start();
    wait_done(400);
    chk_frame("A", 147, 149, 146);
    chk("A.u0.first_rv", first_rv[0], 3);
    chk("A.u1.first_rv", first_rv[1], 5);
    chk("A.u2.first_rv", first_rv[2], 2);
    chk("A.u0.busy_first", busy_first[0], 1);
    chk("A.u0.busy_last", busy_last[0], 146);

    // Frame B: 5-cycle backpressure at index 50, plus an ignored mid-run start.
    tick();
    do_start();
    wait_rel(10);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(o_rv[0] && o_idx[0] == 8'd50) && n < 300) begin
      tick();
      n++;
    end
    chk("B.idx50_cycle", cyc - start_cyc, 53);
    res_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      chk("B.hold_index", int'(o_idx[0]), 50);
      chk("B.hold_dir", int'(o_dir[0]), 1);
      chk("B.hold_counter", int'(o_cnt[0]), 16);
      tick();
    end
    res_ready = 1'b1;
    wait_done(400);
    chk_frame("B", 152, 154, 151);
`ifdef S2_SCHED_STATS_EN
    exp_stall = 5;
`else
    exp_stall = 0;
`endif
    chk("B.u0.stall_cycles", int'(o_stall[0]), exp_stall);
    chk("B.u2.stall_cycles", int'(o_stall[2]), exp_stall);

    // Frame C: abort at cycle 20, then a clean frame.
    tick();
    do_start();
    wait_rel(20);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("C.u%0d.busy_after_abort", i), int'(o_busy[i]), 0);
      chk($sformatf("C.u%0d.rv_after_abort", i), int'(o_rv[i]), 0);
    end
    for (int s = 0; s < 200; s++) tick();
    for (int i = 0; i < NI; i++)
      chk($sformatf("C.u%0d.no_done", i), done_cnt[i], 0);
    do_start();
    wait_done(400);
    chk_frame("C2", 147, 149, 146);

    // Start and abort together in IDLE: no frame.
    tick();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < NI; i++)
        chk($sformatf("SA.u%0d.busy", i), int'(o_busy[i]), 0);
      tick();
    end

    // Frame D: asynchronous reset mid-frame, then a fresh frame.
    do_start();
    wait_rel(70);
    chk("D.u0.busy_before_reset", int'(o_busy[0]), 1);
    reset = 1'b0;
    #1;
    chk_zero_outputs("async_reset");
    tick(); tick();
    reset = 1'b1;
    tick();
    do_start();
    wait_done(400);
    chk_frame("D2", 147, 149, 146);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/s2_conv_scheduler.md
# s2_conv_scheduler

Sequencer for the stage-2 convolution datapath. It runs once per frame, starting when the tensor builder reports the 8x8x3 input tensor complete. It sweeps all 4 filters x 36 output positions (6x6), driving the filter-select and position counters into the combinational tensor-processing path. It tracks results through a fixed-latency pipeline and hands each one to the downstream consumer (FC stage / result store) with a valid/ready handshake and full backpressure.

## Interface
Parameters:
- N_DIR, 4, number of filters swept (dir field width fixed at 2 bits)
- N_POS, 36, output positions per filter (counter field width fixed at 6 bits)
- LAT, 2, cycles from issue to result valid; legal 1..4

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse, input tensor ready (driven by the builder's data_rdy)
- abort  in  1  synchronous flush request
- dir  out  2  filter select to the filter mux
- counter  out  6  output position to tensor processing
- issue_valid  out  1  dir/counter hold a live issue this cycle
- res_valid  out  1  result at res_index is valid
- res_ready  in  1  downstream accepts result
- res_addr  out  8  {dir, counter} of the presented result
- res_index  out  8  dir*36 + counter of the presented result (0..143)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse, frame finished
- stall_cycles  out  16  backpressure statistics (see Configuration)

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: when start=1 and abort=0, go to RUN. abort wins over a simultaneous start. start in any other state is ignored.
- RUN: issue_valid=1. Each enabled cycle the counter advances 0..N_POS-1. On wrap (35 to 0), dir increments. After issuing (N_DIR-1, N_POS-1), go to DRAIN.
- DRAIN: issue_valid=0. Wait until the pipeline is empty and the last result is accepted, then go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Enable: en = !(res_valid && !res_ready). When en=0, the issue counters, state advance and every pipeline stage hold.
- Pipeline: a LAT-deep shift register of {valid, dir, counter}. Its output drives res_valid, res_addr and res_index.
- res_index: computed from the registered fields as dir*36 + counter. Unsigned, 8 bits, no overflow (max 143).
- busy: 1 in RUN and DRAIN.
- abort in RUN/DRAIN: next cycle IDLE, pipeline valids cleared, counters zeroed, no done pulse.
- Reset values: state IDLE; dir, counter, res_addr, res_index, stall_cycles = 0; issue_valid, res_valid, busy, done = 0.
- Reset asserted mid-frame: immediate clear to reset values; the frame is lost.

## Timing
- Start accepted at cycle 0. First issue (0,0) at cycle 1. Without stalls, issue k is at cycle 1+k, for k = 0..143.
- A result appears LAT cycles after its issue when en stays 1.
- Without stalls: last issue at cycle 144, last res_valid at 144+LAT, done at 145+LAT.
- Each stall cycle adds exactly one cycle to the frame.
- res_valid may not drop, and res_addr may not change, while res_ready=0.
- dir/counter are registered outputs with no combinational path from res_ready to them.
- Earliest next accepted start: the cycle after done.

## Configuration
- Macro S2_SCHED_STATS_EN.
- Defined: stall_cycles counts cycles with res_valid=1 and res_ready=0 in the current frame. It saturates at 0xFFFF, clears on start acceptance, and holds its value after done until the next start.
- Undefined: stall_cycles is tied to 0, no counter logic is built, and all other behaviour is identical.

## Test plan
- LAT=2, start pulse, res_ready=1: 144 results with res_index 0..143 in order; res_addr at index 36 = 0x40; done at cycle 147; busy high cycles 1..146.
- res_ready low for 5 cycles when res_index=50 is presented: res_index holds at 50 and dir/counter hold; done at cycle 152; stall_cycles=5 with the macro, 0 without.
- abort at cycle 20: IDLE at cycle 21, res_valid=0, no done pulse; a subsequent start yields a full clean 144-result frame.
- start and abort in the same IDLE cycle: stays IDLE, busy remains 0; start pulses during RUN are ignored and the result count stays 144.
- reset low at cycle 70 mid-frame: all outputs return to reset values asynchronously and do not depend on clk; after release, a new start produces results from index 0.
- LAT=4 and LAT=1 sweeps: first res_valid at cycle 1+LAT; done at 145+LAT.
